// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and scoreboard for the 16x8 register file. Two requesters
// share one write port round-robin. Per-register busy bits feed decode's hazard stall.
module regfile_wb_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_a_valid,
  input  logic [ADDR_W-1:0]        i_a_reg,
  input  logic [DATA_W-1:0]        i_a_data,
  output logic                     o_a_ready,
  input  logic                     i_b_valid,
  input  logic [ADDR_W-1:0]        i_b_reg,
  input  logic [DATA_W-1:0]        i_b_data,
  output logic                     o_b_ready,
  input  logic                     i_issue_valid,
  input  logic [ADDR_W-1:0]        i_issue_reg,
  input  logic                     i_flush,
  input  logic [ADDR_W-1:0]        i_rd_reg1,
  input  logic [ADDR_W-1:0]        i_rd_reg2,
  output logic                     o_hazard,
  output logic                     o_write_en,
  output logic [ADDR_W-1:0]        o_write_reg,
  output logic [DATA_W-1:0]        o_write_data,
  output logic [(1<<ADDR_W)-1:0]   o_busy,
  output logic [7:0]               o_wr_count
);
  localparam int NREG = 1 << ADDR_W;

  // Handshake: a requester holds valid/reg/data stable until it sees ready;
  // the transfer happens on the edge where valid && ready are both high.
  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_e;

  ptr_e                ptr_q, ptr_d;
  logic                a_gnt, b_gnt;
  logic                acc_wen;
  logic [ADDR_W-1:0]   acc_reg;
  logic [DATA_W-1:0]   acc_data;
  logic                write_en_q;
  logic [ADDR_W-1:0]   write_reg_q;
  logic [DATA_W-1:0]   write_data_q;
  logic [NREG-1:0]     busy_q, busy_d;
  logic [7:0]          wr_count_q;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    ptr_d = ptr_q;
    if (i_reset) begin
      if (i_a_valid && (!i_b_valid || ptr_q == PTR_A)) a_gnt = 1'b1;
      else if (i_b_valid)                              b_gnt = 1'b1;
    end
    if (a_gnt)      ptr_d = PTR_B;
    else if (b_gnt) ptr_d = PTR_A;
  end

  // Writes to register 0 are accepted but never reach the register file.
  always_comb begin
    acc_reg  = b_gnt ? i_b_reg  : i_a_reg;
    acc_data = b_gnt ? i_b_data : i_a_data;
    acc_wen  = (a_gnt || b_gnt) && (acc_reg != '0);
  end

  // Issue sets after the commit clears so a same-edge set wins; flush beats both.
  always_comb begin
    busy_d = busy_q;
    if (write_en_q) busy_d[write_reg_q] = 1'b0;
    if (i_issue_valid && i_issue_reg != '0) busy_d[i_issue_reg] = 1'b1;
    if (i_flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ptr_q        <= PTR_A;
      write_en_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
      wr_count_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      write_en_q <= acc_wen;
      if (acc_wen) begin
        write_reg_q  <= acc_reg;
        write_data_q <= acc_data;
      end
      busy_q <= busy_d;
      if (write_en_q) wr_count_q <= wr_count_q + 8'd1;
    end
  end

  assign o_a_ready    = a_gnt;
  assign o_b_ready    = b_gnt;
  assign o_hazard     = busy_q[i_rd_reg1] | busy_q[i_rd_reg2];
  assign o_write_en   = write_en_q;
  assign o_write_reg  = write_reg_q;
  assign o_write_data = write_data_q;
  assign o_busy       = busy_q;
  assign o_wr_count   = wr_count_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a transaction-level model is checked
// every negedge, plus literal expectations at the key points of each scenario.
module tb_regfile_wb_arbiter;
  logic        i_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [3:0]  a_reg = '0, b_reg = '0;
  logic [7:0]  a_data = '0, b_data = '0;
  logic        a_ready, b_ready;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_reg = '0;
  logic        flush = 1'b0;
  logic [3:0]  rd1 = '0, rd2 = '0;
  logic        hazard, write_en;
  logic [3:0]  write_reg;
  logic [7:0]  write_data;
  logic [15:0] busy;
  logic [7:0]  wr_count;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_arbiter #(.DATA_W(8), .ADDR_W(4)) dut (
    .i_clk(i_clk), .i_reset(rst_n),
    .i_a_valid(a_valid), .i_a_reg(a_reg), .i_a_data(a_data), .o_a_ready(a_ready),
    .i_b_valid(b_valid), .i_b_reg(b_reg), .i_b_data(b_data), .o_b_ready(b_ready),
    .i_issue_valid(issue_valid), .i_issue_reg(issue_reg), .i_flush(flush),
    .i_rd_reg1(rd1), .i_rd_reg2(rd2), .o_hazard(hazard),
    .o_write_en(write_en), .o_write_reg(write_reg), .o_write_data(write_data),
    .o_busy(busy), .o_wr_count(wr_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       m_b_turn = 0;      // when both ask, B wins if set
  bit       m_busy[16];
  bit       m_wen = 0;
  int       m_wreg = 0;
  int       m_wdata = 0;
  int       m_cnt = 0;

  function automatic int winner();  // 0 none, 1 A, 2 B
    if (!rst_n) return 0;
    if (a_valid && b_valid) return m_b_turn ? 2 : 1;
    if (a_valid) return 1;
    if (b_valid) return 2;
    return 0;
  endfunction

  always @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_b_turn = 0; m_wen = 0; m_wreg = 0; m_wdata = 0; m_cnt = 0;
      foreach (m_busy[r]) m_busy[r] = 0;
    end else begin
      int w, r, d;
      if (m_wen) begin
        m_busy[m_wreg] = 0;
        m_cnt = (m_cnt + 1) % 256;
      end
      if (issue_valid && issue_reg != 0) m_busy[issue_reg] = 1;
      if (flush) foreach (m_busy[k]) m_busy[k] = 0;
      w = winner();
      r = (w == 2) ? int'(b_reg) : int'(a_reg);
      d = (w == 2) ? int'(b_data) : int'(a_data);
      m_wen = (w != 0) && (r != 0);
      if (m_wen) begin m_wreg = r; m_wdata = d; end
      if (w == 1) m_b_turn = 1;
      if (w == 2) m_b_turn = 0;
    end
  end

  always @(negedge i_clk) begin
    logic [15:0] eb;
    int w;
    for (int k = 0; k < 16; k++) eb[k] = m_busy[k];
    w = winner();
    chk("a_ready", a_ready, w == 1);
    chk("b_ready", b_ready, w == 2);
    chk("hazard", hazard, m_busy[rd1] | m_busy[rd2]);
    chk("write_en", write_en, m_wen);
    chk("write_reg", write_reg, m_wreg);
    chk("write_data", write_data, m_wdata);
    chk("busy", busy, eb);
    chk("wr_count", wr_count, m_cnt);
  end

  // ---------------- driver ----------------
  task automatic cyc();
    @(posedge i_clk); #1;
  endtask

  task automatic neg();
    @(negedge i_clk); #1;
  endtask

  initial begin
    // reset held with both requesters valid
    a_valid = 1; a_reg = 4'd3; a_data = 8'h5A;
    b_valid = 1; b_reg = 4'd2; b_data = 8'h22;
    repeat (2) cyc();
    neg();
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_write_en", write_en, 0);
    chk("rst_count", wr_count, 0);
    chk("rst_busy", busy, 0);

    // release with A only
    cyc(); rst_n = 1; b_valid = 0;
    neg(); chk("t1_a_ready", a_ready, 1);
    cyc(); a_valid = 0;
    neg();
    chk("t1_wen", write_en, 1);
    chk("t1_wreg", write_reg, 3);
    chk("t1_wdata", write_data, 8'h5A);
    cyc(); neg();
    chk("t1_count", wr_count, 1);

    // single B write leaves the pointer on A
    cyc(); b_valid = 1; b_reg = 4'd8; b_data = 8'h88;
    neg(); chk("t2_b_only", b_ready, 1);
    cyc();
    a_valid = 1; a_reg = 4'd1; a_data = 8'h11;
    b_valid = 1; b_reg = 4'd2; b_data = 8'h22;
    for (int k = 0; k < 4; k++) begin
      neg();
      if (k > 0) chk("t2_wreg_seq", write_reg, (k % 2 == 1) ? 1 : 2);
      chk("t2_rr_grant", (k % 2 == 0) ? a_ready : b_ready, 1);
      cyc();
    end
    a_valid = 0; b_valid = 0;
    neg(); chk("t2_last_wreg", write_reg, 2);
    cyc(); neg(); chk("t2_count", wr_count, 6);

    // issue reg 5, hazard until the commit
    cyc(); issue_valid = 1; issue_reg = 4'd5; rd1 = 4'd5; rd2 = 4'd0;
    neg(); chk("t3_hz_pre", hazard, 0);
    cyc(); issue_valid = 0; a_valid = 1; a_reg = 4'd5; a_data = 8'h55;
    neg(); chk("t3_hz_set", hazard, 1);
    cyc(); a_valid = 0;
    neg(); chk("t3_hz_wen", hazard, 1);
    cyc(); neg();
    chk("t3_hz_clr", hazard, 0);
    chk("t3_busy5", busy[5], 0);

    // same-edge commit and re-issue of reg 7
    cyc(); issue_valid = 1; issue_reg = 4'd7; rd1 = 4'd7;
    cyc(); issue_valid = 0; a_valid = 1; a_reg = 4'd7; a_data = 8'h77;
    cyc(); a_valid = 0; issue_valid = 1; issue_reg = 4'd7;
    neg(); chk("t4_wreg", write_reg, 7);
    cyc(); issue_valid = 0;
    neg();
    chk("t4_busy7", busy[7], 1);
    chk("t4_hz", hazard, 1);

    // register 0 write and issue are discarded
    cyc(); b_valid = 1; b_reg = 4'd0; b_data = 8'hFF; issue_valid = 1; issue_reg = 4'd0;
    neg(); chk("t5_b_ready", b_ready, 1);
    cyc(); b_valid = 0; issue_valid = 0;
    neg();
    chk("t5_wen", write_en, 0);
    chk("t5_count", wr_count, 8);
    chk("t5_busy", busy, 16'h0080);
    chk("t5_wreg_hold", write_reg, 7);

    // flush beats a same-cycle issue
    cyc(); issue_valid = 1; issue_reg = 4'd2;
    cyc(); issue_reg = 4'd4;
    cyc(); issue_reg = 4'd9;
    cyc(); issue_reg = 4'd6; flush = 1;
    neg(); chk("t6_busy_pre", busy, 16'h0294);
    cyc(); issue_valid = 0; flush = 0; a_valid = 1; a_reg = 4'd3; a_data = 8'h33;
    neg();
    chk("t6_busy_flush", busy, 0);
    chk("t6_a_ready", a_ready, 1);
    cyc(); a_valid = 0;
    neg(); chk("t6_wen", write_en, 1);
    rst_n = 0; #1;
    chk("t6_rst_wen", write_en, 0);
    chk("t6_rst_count", wr_count, 0);
    chk("t6_rst_wreg", write_reg, 0);
    cyc(); rst_n = 1;
    repeat (3) cyc();
    neg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
